// File: rtl/ristretto_exe_stage_pkg.sv
// Shared exe-stage definitions: shift mode codes plus the sequential-shift dispatcher
// state encoding and counter width.
package ristretto_exe_stage_pkg;

    localparam logic [1:0] SHIFT_LEFT   = 2'b00;
    localparam logic [1:0] SHIFT_RIGHT  = 2'b01;
    localparam logic [1:0] SHIFT_ARIGHT = 2'b10;

    localparam int SDISP_CNT_W = 5;

    typedef enum logic [1:0] {
        SDISP_IDLE,
        SDISP_ISSUE,
        SDISP_CAPTURE,
        SDISP_RESP
    } sdisp_state_t;

    function automatic logic isLegalShiftMode(input logic [1:0] mode);
        return (mode == SHIFT_LEFT) || (mode == SHIFT_RIGHT) || (mode == SHIFT_ARIGHT);
    endfunction

endpackage

// File: rtl/ristretto_shift_dispatcher_if.sv
// Request/response bus between exe control and the shift dispatcher; signal
// suffixes are relative to the dispatcher (slave side).
interface ristretto_shift_dispatcher_if #(
    parameter int DataWidth = 32
);

    logic                 sdisp_req_valid_i;
    logic                 sdisp_req_ready_o;
    logic [DataWidth-1:0] sdisp_op_a_i;
    logic [4:0]           sdisp_amt_i;
    logic [1:0]           sdisp_mode_i;
    logic                 sdisp_rsp_valid_o;
    logic                 sdisp_rsp_ready_i;
    logic [DataWidth-1:0] sdisp_result_o;
    logic                 sdisp_illegal_o;

    modport master (
        output sdisp_req_valid_i, sdisp_op_a_i, sdisp_amt_i, sdisp_mode_i, sdisp_rsp_ready_i,
        input  sdisp_req_ready_o, sdisp_rsp_valid_o, sdisp_result_o, sdisp_illegal_o
    );

    modport slave (
        input  sdisp_req_valid_i, sdisp_op_a_i, sdisp_amt_i, sdisp_mode_i, sdisp_rsp_ready_i,
        output sdisp_req_ready_o, sdisp_rsp_valid_o, sdisp_result_o, sdisp_illegal_o
    );

endinterface

// File: rtl/ristretto_sdisp_fastpath.sv
// Combinational 0/1-bit shifter used for requests that never need the sequential
// shifter. Illegal modes and zero amounts pass the operand through unchanged.
module ristretto_sdisp_fastpath
    import ristretto_exe_stage_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic [DataWidth-1:0] op_a_i,
    input  logic [4:0]           amt_i,
    input  logic [1:0]           mode_i,
    output logic [DataWidth-1:0] data_o
);

    always_comb begin
        data_o = op_a_i;
        if (amt_i == 5'd1) begin
            case (mode_i)
                SHIFT_LEFT:   data_o = op_a_i << 1;
                SHIFT_RIGHT:  data_o = op_a_i >> 1;
                SHIFT_ARIGHT: data_o = {op_a_i[DataWidth-1], op_a_i[DataWidth-1:1]};
                default:      data_o = op_a_i;
            endcase
        end
    end

endmodule

// File: rtl/ristretto_shift_dispatcher.sv
// Initiator side of the sequential-shift handshake: resolves 0/1-bit shifts locally,
// otherwise strobes the sequential shifter for N cycles. Optional busy-line monitor
// enabled by defining RISTRETTO_SDISP_BUSY_CHECK_EN.
module ristretto_shift_dispatcher
    import ristretto_exe_stage_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    ristretto_shift_dispatcher_if.slave   sdisp,
    output logic                          sshft_en_o,
    output logic [DataWidth-1:0]          sshft_operand_a_o,
    output logic [4:0]                    sshft_operand_b_o,
    output logic [1:0]                    sshft_mode_o,
    input  logic                          sshft_busy_i,
    input  logic [DataWidth-1:0]          sshft_result_i,
    output logic                          sdisp_fault_o
);

    sdisp_state_t           state_q;
    logic                   reqReady_q;
    logic                   rspValid_q;
    logic [DataWidth-1:0]   result_q;
    logic                   illegal_q;
    logic                   en_q;
    logic [DataWidth-1:0]   opA_q;
    logic [4:0]             opB_q;
    logic [1:0]             mode_q;
    logic [SDISP_CNT_W-1:0] cnt_q;

    logic                   illegalMode_d;
    logic                   fastPath_d;
    logic [DataWidth-1:0]   fastData_d;
    logic [SDISP_CNT_W-1:0] lastCnt_d;

    ristretto_sdisp_fastpath #(
        .DataWidth (DataWidth)
    ) u_fastpath (
        .op_a_i (sdisp.sdisp_op_a_i),
        .amt_i  (sdisp.sdisp_amt_i),
        .mode_i (sdisp.sdisp_mode_i),
        .data_o (fastData_d)
    );

    assign illegalMode_d = !isLegalShiftMode(sdisp.sdisp_mode_i);
    assign fastPath_d    = illegalMode_d || (sdisp.sdisp_amt_i <= 5'd1);
    assign lastCnt_d     = SDISP_CNT_W'(opB_q - 5'd1);

    // en drops on the edge that ends the Nth ISSUE cycle, so the shifter sees exactly N enabled edges.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= SDISP_IDLE;
            reqReady_q <= 1'b1;
            rspValid_q <= 1'b0;
            result_q   <= '0;
            illegal_q  <= 1'b0;
            en_q       <= 1'b0;
            opA_q      <= '0;
            opB_q      <= '0;
            mode_q     <= SHIFT_LEFT;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                SDISP_IDLE: begin
                    if (sdisp.sdisp_req_valid_i && reqReady_q) begin
                        reqReady_q <= 1'b0;
                        opA_q      <= sdisp.sdisp_op_a_i;
                        opB_q      <= sdisp.sdisp_amt_i;
                        mode_q     <= sdisp.sdisp_mode_i;
                        illegal_q  <= illegalMode_d;
                        if (fastPath_d) begin
                            result_q   <= fastData_d;
                            rspValid_q <= 1'b1;
                            state_q    <= SDISP_RESP;
                        end else begin
                            en_q    <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= SDISP_ISSUE;
                        end
                    end
                end
                SDISP_ISSUE: begin
                    if (cnt_q == lastCnt_d) begin
                        en_q    <= 1'b0;
                        state_q <= SDISP_CAPTURE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SDISP_CAPTURE: begin
                    result_q   <= sshft_result_i;
                    rspValid_q <= 1'b1;
                    state_q    <= SDISP_RESP;
                end
                SDISP_RESP: begin
                    if (sdisp.sdisp_rsp_ready_i) begin
                        rspValid_q <= 1'b0;
                        reqReady_q <= 1'b1;
                        state_q    <= SDISP_IDLE;
                    end
                end
                default: begin
                    state_q <= SDISP_IDLE;
                end
            endcase
        end
    end

    assign sdisp.sdisp_req_ready_o = reqReady_q;
    assign sdisp.sdisp_rsp_valid_o = rspValid_q;
    assign sdisp.sdisp_result_o    = result_q;
    assign sdisp.sdisp_illegal_o   = illegal_q;
    assign sshft_en_o              = en_q;
    assign sshft_operand_a_o       = opA_q;
    assign sshft_operand_b_o       = opB_q;
    assign sshft_mode_o            = mode_q;

`ifdef RISTRETTO_SDISP_BUSY_CHECK_EN
    logic fault_q;

    // The shifter raises busy one edge after the first enable and must be idle once en drops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fault_q <= 1'b0;
        end else if (((state_q == SDISP_ISSUE) && (cnt_q != '0) && !sshft_busy_i) ||
                     ((state_q == SDISP_CAPTURE) && sshft_busy_i)) begin
            fault_q <= 1'b1;
        end
    end

    assign sdisp_fault_o = fault_q;
`else
    logic unusedBusy;
    assign unusedBusy    = sshft_busy_i;
    assign sdisp_fault_o = 1'b0;
`endif

endmodule

// File: tb/tb_ristretto_shift_dispatcher.sv
// Directed bench for ristretto_shift_dispatcher paired with a behavioural stand-in
// for the sequential shifter (one bit per enabled edge, busy while running).
module tb_ristretto_shift_dispatcher;

    logic        clk;
    logic        rst;
    logic        sshftEn;
    logic [31:0] sshftOpA;
    logic [4:0]  sshftOpB;
    logic [1:0]  sshftMode;
    logic        sshftBusy;
    logic [31:0] sshftResult;
    logic        fault;

    logic [31:0] shAcc;
    logic        shRunning;
    logic        forceBusyLow;

    int passCount;
    int checkCount;
    int failCount;
    int edges;
    int enCycles;
    logic sawValid;
    logic sawEn;

    ristretto_shift_dispatcher_if #(.DataWidth(32)) bus ();

    ristretto_shift_dispatcher #(
        .DataWidth (32)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .sdisp             (bus.slave),
        .sshft_en_o        (sshftEn),
        .sshft_operand_a_o (sshftOpA),
        .sshft_operand_b_o (sshftOpB),
        .sshft_mode_o      (sshftMode),
        .sshft_busy_i      (sshftBusy),
        .sshft_result_i    (sshftResult),
        .sdisp_fault_o     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] shiftOne(input logic [31:0] v, input logic [1:0] m);
        case (m)
            2'b00:   return v << 1;
            2'b01:   return v >> 1;
            2'b10:   return {v[31], v[31:1]};
            default: return v;
        endcase
    endfunction

    // Shifter stand-in: synchronous reset, first enabled edge loads the shifted operand.
    always @(posedge clk) begin
        if (rst) begin
            shAcc     <= '0;
            shRunning <= 1'b0;
        end else if (sshftEn) begin
            shAcc     <= shiftOne(shRunning ? shAcc : sshftOpA, sshftMode);
            shRunning <= 1'b1;
        end else begin
            shRunning <= 1'b0;
        end
    end

    assign sshftBusy   = sshftEn && shRunning && !forceBusyLow;
    assign sshftResult = shAcc;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] opA, input logic [4:0] amt, input logic [1:0] mode);
        @(negedge clk);
        bus.sdisp_req_valid_i = 1'b1;
        bus.sdisp_op_a_i      = opA;
        bus.sdisp_amt_i       = amt;
        bus.sdisp_mode_i      = mode;
        @(posedge clk);
        #1;
        bus.sdisp_req_valid_i = 1'b0;
    endtask

    task automatic waitRsp(output int nEdges, output int nEn);
        nEdges = 0;
        nEn    = 0;
        do begin
            @(negedge clk);
            nEdges++;
            if (sshftEn) nEn++;
        end while (!bus.sdisp_rsp_valid_o && nEdges < 64);
    endtask

    task automatic releaseRsp();
        @(negedge clk);
        bus.sdisp_rsp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.sdisp_rsp_ready_i = 1'b0;
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        failCount  = 0;
        forceBusyLow = 1'b0;
        bus.sdisp_req_valid_i = 1'b0;
        bus.sdisp_op_a_i      = '0;
        bus.sdisp_amt_i       = '0;
        bus.sdisp_mode_i      = '0;
        bus.sdisp_rsp_ready_i = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_req_ready", 32'(bus.sdisp_req_ready_o), 32'd1);
        checkOutput("reset_rsp_valid", 32'(bus.sdisp_rsp_valid_o), 32'd0);
        checkOutput("reset_result", bus.sdisp_result_o, 32'h0);
        checkOutput("reset_illegal", 32'(bus.sdisp_illegal_o), 32'd0);
        checkOutput("reset_en", 32'(sshftEn), 32'd0);
        checkOutput("reset_op_a", sshftOpA, 32'h0);
        checkOutput("reset_fault", 32'(fault), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] LEFT 0x1 by 4");
        applyStimulus(32'h0000_0001, 5'd4, 2'b00);
        waitRsp(edges, enCycles);
        checkOutput("left4_result", bus.sdisp_result_o, 32'h0000_0010);
        checkOutput("left4_latency", 32'(edges), 32'd6);
        checkOutput("left4_en_cycles", 32'(enCycles), 32'd4);
        checkOutput("left4_illegal", 32'(bus.sdisp_illegal_o), 32'd0);
        releaseRsp();
        checkOutput("left4_ready_back", 32'(bus.sdisp_req_ready_o), 32'd1);

        $display("[TB] ARIGHT 0x80000000 by 31");
        applyStimulus(32'h8000_0000, 5'd31, 2'b10);
        waitRsp(edges, enCycles);
        checkOutput("aright31_result", bus.sdisp_result_o, 32'hFFFF_FFFF);
        checkOutput("aright31_latency", 32'(edges), 32'd33);
        checkOutput("aright31_en_cycles", 32'(enCycles), 32'd31);
        releaseRsp();

        $display("[TB] RIGHT 0x80000000 by 31");
        applyStimulus(32'h8000_0000, 5'd31, 2'b01);
        waitRsp(edges, enCycles);
        checkOutput("right31_result", bus.sdisp_result_o, 32'h0000_0001);
        releaseRsp();

        $display("[TB] N=0 passthrough");
        applyStimulus(32'hDEAD_BEEF, 5'd0, 2'b00);
        waitRsp(edges, enCycles);
        checkOutput("n0_result", bus.sdisp_result_o, 32'hDEAD_BEEF);
        checkOutput("n0_latency", 32'(edges), 32'd1);
        checkOutput("n0_en_cycles", 32'(enCycles), 32'd0);
        releaseRsp();

        $display("[TB] N=1 ARIGHT");
        applyStimulus(32'h8000_0002, 5'd1, 2'b10);
        waitRsp(edges, enCycles);
        checkOutput("n1_result", bus.sdisp_result_o, 32'hC000_0001);
        checkOutput("n1_latency", 32'(edges), 32'd1);
        checkOutput("n1_en_cycles", 32'(enCycles), 32'd0);
        releaseRsp();

        $display("[TB] illegal mode with response stall");
        applyStimulus(32'h1234_5678, 5'd5, 2'b11);
        waitRsp(edges, enCycles);
        checkOutput("illegal_flag", 32'(bus.sdisp_illegal_o), 32'd1);
        checkOutput("illegal_latency", 32'(edges), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("stall_result", bus.sdisp_result_o, 32'h1234_5678);
            checkOutput("stall_req_ready", 32'(bus.sdisp_req_ready_o), 32'd0);
            checkOutput("stall_rsp_valid", 32'(bus.sdisp_rsp_valid_o), 32'd1);
        end
        checkOutput("illegal_en_never", 32'(sshftEn), 32'd0);
        releaseRsp();

        $display("[TB] reset during ISSUE");
        applyStimulus(32'h0000_0001, 5'd20, 2'b00);
        repeat (7) @(posedge clk);
        #2;
        checkOutput("issue_en_before_rst", 32'(sshftEn), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_en_async", 32'(sshftEn), 32'd0);
        checkOutput("rst_rsp_valid", 32'(bus.sdisp_rsp_valid_o), 32'd0);
        checkOutput("rst_req_ready", 32'(bus.sdisp_req_ready_o), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        sawValid = 1'b0;
        sawEn    = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            sawValid = sawValid | bus.sdisp_rsp_valid_o;
            sawEn    = sawEn | sshftEn;
        end
        checkOutput("rst_no_rsp", 32'(sawValid), 32'd0);
        checkOutput("rst_no_en", 32'(sawEn), 32'd0);

        $display("[TB] LEFT 0x1 by 3 after reset");
        applyStimulus(32'h0000_0001, 5'd3, 2'b00);
        waitRsp(edges, enCycles);
        checkOutput("left3_result", bus.sdisp_result_o, 32'h0000_0008);
        checkOutput("left3_latency", 32'(edges), 32'd5);
        checkOutput("left3_illegal", 32'(bus.sdisp_illegal_o), 32'd0);
        releaseRsp();

`ifdef RISTRETTO_SDISP_BUSY_CHECK_EN
        $display("[TB] busy line forced low");
        checkOutput("fault_clean", 32'(fault), 32'd0);
        forceBusyLow = 1'b1;
        applyStimulus(32'h0000_0001, 5'd4, 2'b00);
        waitRsp(edges, enCycles);
        forceBusyLow = 1'b0;
        checkOutput("fault_set", 32'(fault), 32'd1);
        checkOutput("fault_dataflow", bus.sdisp_result_o, 32'h0000_0010);
        releaseRsp();
        applyStimulus(32'h0000_0001, 5'd2, 2'b00);
        waitRsp(edges, enCycles);
        releaseRsp();
        checkOutput("fault_sticky", 32'(fault), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("fault_cleared", 32'(fault), 32'd0);
        @(negedge clk);
        rst = 1'b0;
`else
        checkOutput("fault_tied_low", 32'(fault), 32'd0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
